// File: rtl/sync_proc_ni.sv
// -----------------------------------------------------------------------------
// sync_proc_ni
// Processor-side network interface for one mesh node.
//   TX path: clocked valid/ready packet -> router injection port using
//            2-phase bundled-data req/ack (ni_data_o / ni_req_o / ni_ack_i).
//   RX path: router ejection port (ni_data_i / ni_req_i / ni_ack_o) ->
//            clocked valid/ready flit stream.
//
// Flit layout (PW = N-XW-YW-2):
//   [N-1 -: XW] dest_x | [N-1-XW -: YW] dest_y | [PW+1] dir_x | [PW] dir_y |
//   [PW-1:0] payload.  dir_x = dest_x > SELFX, dir_y = dest_y > SELFY.
//
// Ports:
//   clk, rst (async, active-low)
//   tx_valid/tx_ready, tx_dest_x, tx_dest_y, tx_payload   processor TX side
//   ni_data_o, ni_req_o, ni_ack_i (async)                   router injection
//   ni_data_i, ni_req_i (async), ni_ack_o                   router ejection
//   rx_valid/rx_ready, rx_data                              processor RX side
//   rx_misroute                                             sticky dest error
//
// Optional feature macro: NI_MISROUTE_CHK_EN
//   defined   -> each RX capture compares dest against (SELFX,SELFY) and sets
//                the sticky rx_misroute flag on mismatch (flit still delivered)
//   undefined -> no comparators, rx_misroute tied low
// -----------------------------------------------------------------------------
module sync_proc_ni #(
    parameter int N           = 32,
    parameter int XW          = 2,
    parameter int YW          = 2,
    parameter int SELFX       = 0,
    parameter int SELFY       = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [XW-1:0]        tx_dest_x,
    input  logic [YW-1:0]        tx_dest_y,
    input  logic [N-XW-YW-3:0]   tx_payload,
    output logic [N-1:0]         ni_data_o,
    output logic                 ni_req_o,
    input  logic                 ni_ack_i,
    input  logic [N-1:0]         ni_data_i,
    input  logic                 ni_req_i,
    output logic                 ni_ack_o,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [N-1:0]         rx_data,
    output logic                 rx_misroute
);

    localparam int PW = N - XW - YW - 2;
    localparam logic [XW-1:0] SELF_X_C = XW'(SELFX);
    localparam logic [YW-1:0] SELF_Y_C = YW'(SELFY);

    typedef enum logic [1:0] {
        TX_IDLE     = 2'd0,
        TX_LAUNCH   = 2'd1,
        TX_WAIT_ACK = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_t;

    // Assemble an outgoing flit; the direction hints are precomputed here so
    // the router does not need its own comparators on the injection port.
    function automatic logic [N-1:0] build_flit(
        input logic [XW-1:0] dx,
        input logic [YW-1:0] dy,
        input logic [PW-1:0] pl
    );
        build_flit = {dx, dy, (dx > SELF_X_C), (dy > SELF_Y_C), pl};
    endfunction

    tx_state_t              tx_state_r;
    tx_state_t              tx_next_s;
    rx_state_t              rx_state_r;
    rx_state_t              rx_next_s;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic [SYNC_STAGES-1:0] req_sync_r;
    logic                   ack_sync_s;
    logic                   req_sync_s;
    logic [N-1:0]           tx_data_r;
    logic                   tx_req_r;
    logic                   tx_load_s;
    logic                   tx_toggle_s;
    logic [N-1:0]           rx_data_r;
    logic                   rx_ack_r;
    logic                   rx_capture_s;

    assign ack_sync_s = ack_sync_r[SYNC_STAGES-1];
    assign req_sync_s = req_sync_r[SYNC_STAGES-1];

    // Synchronizer chains for the two asynchronous handshake inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_sync_r <= '0;
            req_sync_r <= '0;
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ni_ack_i};
            req_sync_r <= {req_sync_r[SYNC_STAGES-2:0], ni_req_i};
        end
    end

    // TX next-state and datapath control.
    always_comb begin
        tx_next_s   = tx_state_r;
        tx_load_s   = 1'b0;
        tx_toggle_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_load_s = 1'b1;
                    tx_next_s = TX_LAUNCH;
                end else begin
                    tx_next_s = TX_IDLE;
                end
            end
            TX_LAUNCH: begin
                // Data was registered last cycle, so it is already stable
                // when the request edge reaches the router.
                tx_toggle_s = 1'b1;
                tx_next_s   = TX_WAIT_ACK;
            end
            TX_WAIT_ACK: begin
                if (ack_sync_s == tx_req_r) begin
                    tx_next_s = TX_IDLE;
                end else begin
                    tx_next_s = TX_WAIT_ACK;
                end
            end
            default: begin
                tx_next_s = TX_IDLE;
            end
        endcase
    end

    // TX state, flit register and 2-phase request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= TX_IDLE;
            tx_data_r  <= '0;
            tx_req_r   <= 1'b0;
        end else begin
            tx_state_r <= tx_next_s;
            if (tx_load_s) begin
                tx_data_r <= build_flit(tx_dest_x, tx_dest_y, tx_payload);
            end
            if (tx_toggle_s) begin
                tx_req_r <= ~tx_req_r;
            end
        end
    end

    // RX next-state: capture a pending router request only while empty, so a
    // request arriving while full is simply left un-acknowledged.
    always_comb begin
        rx_next_s    = rx_state_r;
        rx_capture_s = 1'b0;
        case (rx_state_r)
            RX_EMPTY: begin
                if (req_sync_s != rx_ack_r) begin
                    rx_capture_s = 1'b1;
                    rx_next_s    = RX_FULL;
                end else begin
                    rx_next_s = RX_EMPTY;
                end
            end
            RX_FULL: begin
                if (rx_ready) begin
                    rx_next_s = RX_EMPTY;
                end else begin
                    rx_next_s = RX_FULL;
                end
            end
            default: begin
                rx_next_s = RX_EMPTY;
            end
        endcase
    end

    // RX state, capture register and 2-phase acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r <= RX_EMPTY;
            rx_data_r  <= '0;
            rx_ack_r   <= 1'b0;
        end else begin
            rx_state_r <= rx_next_s;
            if (rx_capture_s) begin
                rx_data_r <= ni_data_i;
                rx_ack_r  <= ~rx_ack_r;
            end
        end
    end

`ifdef NI_MISROUTE_CHK_EN
    logic misroute_r;

    // Sticky destination-mismatch flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misroute_r <= 1'b0;
        end else if (rx_capture_s &&
                     ((ni_data_i[N-1 -: XW] != SELF_X_C) ||
                      (ni_data_i[N-1-XW -: YW] != SELF_Y_C))) begin
            misroute_r <= 1'b1;
        end else begin
            misroute_r <= misroute_r;
        end
    end

    assign rx_misroute = misroute_r;
`else
    assign rx_misroute = 1'b0;
`endif

    assign tx_ready  = (tx_state_r == TX_IDLE);
    assign ni_data_o = tx_data_r;
    assign ni_req_o  = tx_req_r;
    assign ni_ack_o  = rx_ack_r;
    assign rx_valid  = (rx_state_r == RX_FULL);
    assign rx_data   = rx_data_r;

endmodule

// File: tb/tb_sync_proc_ni.sv
// -----------------------------------------------------------------------------
// tb_sync_proc_ni
// Directed, table-driven bench for sync_proc_ni at N=32, XW=YW=2, SELF=(1,1),
// SYNC_STAGES=2. The bench plays the router: it owns ni_ack_i / ni_req_i /
// ni_data_i and tracks the expected 2-phase levels itself.
// -----------------------------------------------------------------------------
module tb_sync_proc_ni;

    localparam int SS = 2;

    typedef struct {
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [25:0] pl;
        logic [31:0] flit;
    } tx_vec_t;

    logic        clk;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_dest_x;
    logic [1:0]  tx_dest_y;
    logic [25:0] tx_payload;
    logic [31:0] ni_data_o;
    logic        ni_req_o;
    logic        ni_ack_i;
    logic [31:0] ni_data_i;
    logic        ni_req_i;
    logic        ni_ack_o;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic        rx_misroute;

    int   checks;
    int   errors;
    logic exp_req;
    logic exp_ack;
    logic exp_mis;

    tx_vec_t txv [5];
    logic [31:0] rxv [3];

    sync_proc_ni #(
        .N(32), .XW(2), .YW(2), .SELFX(1), .SELFY(1), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y), .tx_payload(tx_payload),
        .ni_data_o(ni_data_o), .ni_req_o(ni_req_o), .ni_ack_i(ni_ack_i),
        .ni_data_i(ni_data_i), .ni_req_i(ni_req_i), .ni_ack_o(ni_ack_o),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_misroute(rx_misroute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Router acknowledges the current request and we wait for tx_ready.
    task automatic router_ack_and_wait();
        int n;
        ni_ack_i = exp_req;
        n = 0;
        while (!tx_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_latency", n, SS + 1);
    endtask

    task automatic tx_send(input tx_vec_t v);
        tx_dest_x = v.dx; tx_dest_y = v.dy; tx_payload = v.pl; tx_valid = 1'b1;
        check("tx_ready_idle", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("ni_data_o", ni_data_o, v.flit);
        check("req_before_launch", ni_req_o, exp_req);
        check("tx_ready_busy", tx_ready, 0);
        @(negedge clk);
        exp_req = ~exp_req;
        check("req_toggle", ni_req_o, exp_req);
        repeat (3) @(negedge clk);
        check("wait_ack_hold", tx_ready, 0);
        router_ack_and_wait();
    endtask

    // Router presents one flit; waits for capture, then consumes it.
    task automatic rx_recv(input logic [31:0] d);
        int n;
        ni_data_i = d;
        ni_req_i  = ~ni_req_i;
        n = 0;
        while (!rx_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rx_latency", n, SS + 1);
        exp_ack = ~exp_ack;
        check("rx_ack", ni_ack_o, exp_ack);
        check("rx_data", rx_data, d);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_consumed", rx_valid, 0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        exp_req = 1'b0; exp_ack = 1'b0; exp_mis = 1'b0;
        rst = 1'b0; tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_payload = '0;
        ni_ack_i = 1'b0; ni_data_i = '0; ni_req_i = 1'b0; rx_ready = 1'b0;

        txv[0] = '{dx: 2'd2, dy: 2'd0, pl: 26'h0ABCDEF, flit: 32'h88ABCDEF};
        txv[1] = '{dx: 2'd1, dy: 2'd1, pl: 26'h3FFFFFF, flit: 32'h53FFFFFF};
        txv[2] = '{dx: 2'd3, dy: 2'd3, pl: 26'h0000001, flit: 32'hFC000001};
        txv[3] = '{dx: 2'd0, dy: 2'd2, pl: 26'h1555555, flit: 32'h25555555};
        txv[4] = '{dx: 2'd1, dy: 2'd2, pl: 26'h0000000, flit: 32'h64000000};
        rxv[0] = 32'h5000_1234;
        rxv[1] = 32'h5FFF_FFFF;
        rxv[2] = 32'h5400_0000;

        // Reset values
        #12;
        check("rst_ni_data_o", ni_data_o, 0);
        check("rst_ni_req_o", ni_req_o, 0);
        check("rst_ni_ack_o", ni_ack_o, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_misroute", rx_misroute, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back packets with tx_valid held high
        tx_dest_x = txv[0].dx; tx_dest_y = txv[0].dy; tx_payload = txv[0].pl;
        tx_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_data", ni_data_o, txv[0].flit);
        tx_dest_x = txv[1].dx; tx_dest_y = txv[1].dy; tx_payload = txv[1].pl;
        @(negedge clk);
        exp_req = ~exp_req;
        check("b2b_first_req", ni_req_o, exp_req);
        repeat (4) @(negedge clk);
        check("b2b_no_early_accept", ni_data_o, txv[0].flit);
        check("b2b_busy", tx_ready, 0);
        router_ack_and_wait();
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_second_data", ni_data_o, txv[1].flit);
        @(negedge clk);
        exp_req = ~exp_req;
        check("b2b_second_req_1to0", ni_req_o, exp_req);
        router_ack_and_wait();

        // TX vector table
        for (int i = 0; i < 5; i++) begin
            tx_send(txv[i]);
        end

        // RX vector table
        for (int i = 0; i < 3; i++) begin
            rx_recv(rxv[i]);
        end

        // RX held full: data stable, second request not acknowledged
        ni_data_i = 32'h5000_1234;
        ni_req_i  = ~ni_req_i;
        n = 0;
        while (!rx_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("full_latency", n, SS + 1);
        exp_ack = ~exp_ack;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_hold_data", rx_data, 32'h5000_1234);
            check("full_hold_ack", ni_ack_o, exp_ack);
        end
        ni_data_i = 32'h5123_4567;
        ni_req_i  = ~ni_req_i;
        repeat (6) @(negedge clk);
        check("pending_not_acked", ni_ack_o, exp_ack);
        check("pending_data_kept", rx_data, 32'h5000_1234);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("pulse_empties", rx_valid, 0);
        @(negedge clk);
        exp_ack = ~exp_ack;
        check("pending_captured", rx_valid, 1);
        check("pending_data", rx_data, 32'h5123_4567);
        check("pending_ack", ni_ack_o, exp_ack);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;

        // Simultaneous tx accept and rx capture on the same edge
        ni_data_i = 32'h5ABC_0001;
        ni_req_i  = ~ni_req_i;
        repeat (2) @(negedge clk);
        check("sim_rx_not_yet", rx_valid, 0);
        tx_dest_x = txv[2].dx; tx_dest_y = txv[2].dy; tx_payload = txv[2].pl;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        exp_ack = ~exp_ack;
        check("sim_tx_data", ni_data_o, txv[2].flit);
        check("sim_rx_valid", rx_valid, 1);
        check("sim_rx_data", rx_data, 32'h5ABC_0001);
        check("sim_rx_ack", ni_ack_o, exp_ack);
        @(negedge clk);
        exp_req = ~exp_req;
        check("sim_tx_req", ni_req_o, exp_req);
        check("sim_no_extra_ack", ni_ack_o, exp_ack);
        router_ack_and_wait();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("sim_rx_consumed", rx_valid, 0);

        // Misroute flag: dest (0,3) at node (1,1), then a good flit
        check("mis_clear_before", rx_misroute, 0);
`ifdef NI_MISROUTE_CHK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        rx_recv(32'h3000_0ABC);
        check("mis_after_bad", rx_misroute, {31'd0, exp_mis});
        rx_recv(32'h5000_0001);
        check("mis_sticky", rx_misroute, {31'd0, exp_mis});

        // Async reset while TX waits for ack and RX is full
        ni_data_i = 32'h5000_7777;
        ni_req_i  = ~ni_req_i;
        tx_dest_x = txv[1].dx; tx_dest_y = txv[1].dy; tx_payload = txv[1].pl;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", tx_ready, 0);
        check("pre_rst_rx_full", rx_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_ni_data_o", ni_data_o, 0);
        check("arst_ni_req_o", ni_req_o, 0);
        check("arst_ni_ack_o", ni_ack_o, 0);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_rx_data", rx_data, 0);
        check("arst_rx_misroute", rx_misroute, 0);
        ni_ack_i = 1'b0; ni_req_i = 1'b0; ni_data_i = '0;
        exp_req = 1'b0; exp_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Recovery after reset
        tx_send(txv[3]);
        rx_recv(rxv[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_proc_ni.md
# sync_proc_ni

Synchronous processor-side network interface for one mesh node. Converts a clocked valid/ready packet stream into the router's 2-phase bundled-data request/acknowledge injection port, and converts the router's 2-phase ejection port back into a clocked valid/ready stream. It is the processor end of the proc↔router handshake: it drives `proc_data_i`/`req_proc_self` and answers `ack_self_proc`, and it receives `proc_data_o`/`req_self_proc` and drives `ack_proc_self`.

## Interface
Parameters:
- `N`, 32, flit width
- `XW`, 2, destination-x field width
- `YW`, 2, destination-y field width
- `SELFX`, 0, this node's x coordinate
- `SELFY`, 0, this node's y coordinate
- `SYNC_STAGES`, 2, flip-flop depth of each async-input synchronizer (≥2)

Ports (PW = N-XW-YW-2):
- `clk` in 1, clock
- `rst` in 1, reset, asynchronous, active-low
- `tx_valid` in 1, processor has a packet
- `tx_ready` out 1, NI accepts packet this cycle
- `tx_dest_x` in XW, destination x
- `tx_dest_y` in YW, destination y
- `tx_payload` in PW, payload
- `ni_data_o` out N, flit to router (to `proc_data_i`)
- `ni_req_o` out 1, 2-phase request to router (to `req_proc_self`)
- `ni_ack_i` in 1, 2-phase ack from router (from `ack_self_proc`), asynchronous
- `ni_data_i` in N, flit from router (from `proc_data_o`)
- `ni_req_i` in 1, 2-phase request from router (from `req_self_proc`), asynchronous
- `ni_ack_o` out 1, 2-phase ack to router (to `ack_proc_self`)
- `rx_valid` out 1, received flit available
- `rx_ready` in 1, processor consumes flit
- `rx_data` out N, received flit
- `rx_misroute` out 1, sticky destination-mismatch flag (see Configuration)

## Operation
- Flit format: `[N-1 -: XW]` dest_x, `[N-1-XW -: YW]` dest_y, bit PW+1 dir_x = (dest_x > SELFX), bit PW dir_y = (dest_y > SELFY), `[PW-1:0]` payload. Comparisons unsigned.
- 2-phase protocol: each transfer = one toggle of req; completion = ack toggled to equal req. Data stable from req toggle until matching ack toggle.
- TX FSM: IDLE → LAUNCH → WAIT_ACK → IDLE.
  - IDLE: `tx_ready`=1; on `tx_valid` register flit into `ni_data_o`, go LAUNCH.
  - LAUNCH: toggle `ni_req_o` (data already stable one cycle), go WAIT_ACK.
  - WAIT_ACK: when synchronized ack == `ni_req_o`, go IDLE.
- RX FSM: EMPTY, FULL.
  - EMPTY: when synchronized req != `ni_ack_o`, capture `ni_data_i` into `rx_data`, toggle `ni_ack_o` on the same edge, go FULL.
  - FULL: `rx_valid`=1; on `rx_ready` go EMPTY. Pending router request waits (no ack) while FULL.
- TX and RX are independent; simultaneous tx accept and rx capture in one cycle are both performed.
- Loopback destination (dest = self) is sent normally.

## Timing
- Reset values: `ni_data_o`=0, `ni_req_o`=0, `ni_ack_o`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_misroute`=0; TX=IDLE, RX=EMPTY; synchronizers cleared. Reset mid-transfer abandons it; router side must be reset concurrently.
- TX: accept at edge k; `ni_data_o` valid after k; `ni_req_o` toggles at k+1; `tx_ready` returns 1 cycle after synchronized ack matches (ack toggle + SYNC_STAGES..SYNC_STAGES+1 cycles). Back-to-back packets: min 3 + SYNC_STAGES cycles apart.
- RX: router req toggle → `rx_valid` high after SYNC_STAGES+1 edges; `ni_ack_o` toggles on the same edge. `rx_data` held while FULL.
- `tx_ready` is combinational from state only; no path from `tx_valid` or `rx_ready` to any output.

## Configuration
- `NI_MISROUTE_CHK_EN` defined: on each RX capture, if dest_x != SELFX or dest_y != SELFY, `rx_misroute` sets and stays 1 until reset; flit still delivered.
- Undefined: no comparators; `rx_misroute` tied 0.

## Test plan
- N=32, XW=YW=2, SELF=(1,1): send dest (2,0), payload 0x0ABCDEF -> `ni_data_o`=0x88ABCDEF, `ni_req_o` 0→1 one cycle after accept; router ack toggles -> `tx_ready` returns within SYNC_STAGES+1 cycles.
- Two packets back-to-back with `tx_valid` held -> second accept only after first ack; `ni_req_o` toggles 1→0 for second.
- Router req toggle with `ni_data_i`=0x5000_1234, `rx_ready`=0 for 10 cycles -> `rx_valid`=1, `rx_data` stable, `ni_ack_o` toggled once; second router req not acked until `rx_ready` pulse.
- Simultaneous tx accept and rx capture -> both complete, no lost flit or extra toggle.
- Assert `rst`=0 while in WAIT_ACK -> all outputs to reset values within same cycle (async).
- With `NI_MISROUTE_CHK_EN`, receive dest (0,3) at SELF (1,1) -> `rx_misroute`=1 sticky, flit delivered; without macro -> `rx_misroute`=0.
